// File: rtl/instr_deser_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_deser_if
// Purpose  : Serial instruction link plus the core-facing issue outputs of
//            instr_deser.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_deser_if #(
   parameter int CNT_W = 8
);
   logic             ser_frame;
   logic             ser_valid;
   logic             ser_bit;
   logic [3:0]       opcode;
   logic [11:0]      instr;
   logic             btn_edge;
   logic             busy;
   logic             frame_err;
   logic [CNT_W-1:0] words_issued;

   // master drives the serial link, slave is the deserializer
   modport master (
      output ser_frame, ser_valid, ser_bit,
      input  opcode, instr, btn_edge, busy, frame_err, words_issued
   );

   modport slave (
      input  ser_frame, ser_valid, ser_bit,
      output opcode, instr, btn_edge, busy, frame_err, words_issued
   );
endinterface
`default_nettype wire

// File: rtl/instr_deser.sv
`default_nettype none
// ============================================================================
// Module   : instr_deser
// Purpose  : MSB-first serial-to-parallel instruction front end with issue
//            pulse and hold-off. Optional macro INSTR_PARITY_EN adds a 17th
//            even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
module instr_deser #(
   parameter int HOLD_CYCLES = 12,
   parameter int CNT_W       = 8
) (
   input  logic         clk,
   input  logic         rstn,
   instr_deser_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_ISSUE = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES);
`ifdef INSTR_PARITY_EN
   localparam logic [4:0] c_PARITY_IDX = 5'd16;
`else
   localparam logic [4:0] c_LAST_DATA  = 5'd15;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_shift;
   logic [15:0]      w_shift_nxt;
   logic [4:0]       r_bit_cnt;
   logic [4:0]       w_bit_cnt_nxt;
   logic [7:0]       r_hold_cnt;
   logic [7:0]       w_hold_cnt_nxt;
   logic             r_armed;
   logic             w_armed_nxt;
   logic [3:0]       r_opcode;
   logic [3:0]       w_opcode_nxt;
   logic [11:0]      r_instr;
   logic [11:0]      w_instr_nxt;
   logic [CNT_W-1:0] r_words;
   logic [CNT_W-1:0] w_words_nxt;
   logic             r_btn_edge;
   logic             w_btn_edge_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_frame_err;
   logic             w_frame_err_nxt;
   logic             w_strobe;

   assign w_strobe = bus.ser_frame & bus.ser_valid;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_hold_cnt  <= '0;
         r_armed     <= 1'b0;
         r_opcode    <= '0;
         r_instr     <= '0;
         r_words     <= '0;
         r_btn_edge  <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_armed     <= w_armed_nxt;
         r_opcode    <= w_opcode_nxt;
         r_instr     <= w_instr_nxt;
         r_words     <= w_words_nxt;
         r_btn_edge  <= w_btn_edge_nxt;
         r_busy      <= w_busy_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_armed_nxt     = r_armed | ~bus.ser_frame;
      w_opcode_nxt    = r_opcode;
      w_instr_nxt     = r_instr;
      w_words_nxt     = r_words;
      w_frame_err_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            // a frame held high across the previous word never re-arms
            if (r_armed && w_strobe) begin
               w_shift_nxt   = {15'd0, bus.ser_bit};
               w_bit_cnt_nxt = 5'd1;
               w_armed_nxt   = 1'b0;
               w_state_nxt   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (!bus.ser_frame) begin
               w_frame_err_nxt = 1'b1;
               w_shift_nxt     = '0;
               w_bit_cnt_nxt   = '0;
               w_state_nxt     = S_IDLE;
            end else if (bus.ser_valid) begin
`ifdef INSTR_PARITY_EN
               if (r_bit_cnt == c_PARITY_IDX) begin
                  w_bit_cnt_nxt = '0;
                  if ((^r_shift) == bus.ser_bit) begin
                     w_opcode_nxt = r_shift[15:12];
                     w_instr_nxt  = r_shift[11:0];
                     w_words_nxt  = r_words + CNT_W'(1);
                     w_state_nxt  = S_ISSUE;
                  end else begin
                     w_frame_err_nxt = 1'b1;
                     w_state_nxt     = S_IDLE;
                  end
               end else begin
                  w_shift_nxt   = {r_shift[14:0], bus.ser_bit};
                  w_bit_cnt_nxt = r_bit_cnt + 5'd1;
               end
`else
               w_shift_nxt   = {r_shift[14:0], bus.ser_bit};
               w_bit_cnt_nxt = r_bit_cnt + 5'd1;
               if (r_bit_cnt == c_LAST_DATA) begin
                  w_opcode_nxt  = w_shift_nxt[15:12];
                  w_instr_nxt   = w_shift_nxt[11:0];
                  w_words_nxt   = r_words + CNT_W'(1);
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = S_ISSUE;
               end
`endif
            end
         end

         S_ISSUE: begin
            w_frame_err_nxt = w_strobe;
            w_hold_cnt_nxt  = c_HOLD_LOAD;
            w_state_nxt     = S_HOLD;
         end

         S_HOLD: begin
            w_frame_err_nxt = w_strobe;
            w_hold_cnt_nxt  = r_hold_cnt - 8'd1;
            if (r_hold_cnt == 8'd1) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // issue/busy flags are registered alongside the state they decode
   assign w_btn_edge_nxt = (w_state_nxt == S_ISSUE);
   assign w_busy_nxt     = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_HOLD);

   assign bus.opcode       = r_opcode;
   assign bus.instr        = r_instr;
   assign bus.btn_edge     = r_btn_edge;
   assign bus.busy         = r_busy;
   assign bus.frame_err    = r_frame_err;
   assign bus.words_issued = r_words;

endmodule
`default_nettype wire

// File: tb/tb_instr_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_deser
// Purpose  : Directed self-checking bench for instr_deser (HOLD_CYCLES=12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_deser;

`ifdef INSTR_PARITY_EN
   localparam int c_FULL = 17;
`else
   localparam int c_FULL = 16;
`endif

   logic clk;
   logic rstn;
   int   total;
   int   bad;
   int   n_btn;
   int   n_err;
   int   n_both;

   instr_deser_if #(.CNT_W(8)) bus ();

   instr_deser #(.HOLD_CYCLES(12), .CNT_W(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.btn_edge) n_btn <= n_btn + 1;
      if (bus.frame_err) n_err <= n_err + 1;
      if (bus.btn_edge && bus.frame_err) n_both <= n_both + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // returns right after the edge that sampled the last bit; frame left high
   task automatic send_raw(input logic [15:0] w, input logic par, input int nbits, input int gap);
      bus.ser_frame = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         bus.ser_valid = 1'b1;
         bus.ser_bit   = (i < 16) ? w[15-i] : par;
         tick();
         bus.ser_valid = 1'b0;
         if (i != nbits - 1) repeat (gap) tick();
      end
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      send_raw(w, ^w, c_FULL, gap);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      bus.ser_valid = 1'b0;
      while (bus.busy === 1'b1 && n < 60) begin
         tick();
         n++;
      end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s idle_timeout busy=%b exp=0", tag, bus.busy); end
   endtask

   task automatic test_reset();
      rstn = 1'b0; bus.ser_frame = 1'b0; bus.ser_valid = 1'b0; bus.ser_bit = 1'b0;
      tick(); tick();
      total++; if (bus.opcode !== 4'h0) begin bad++; $display("FAIL reset opcode got=%h exp=0", bus.opcode); end
      total++; if (bus.instr !== 12'h000) begin bad++; $display("FAIL reset instr got=%h exp=0", bus.instr); end
      total++; if ({bus.btn_edge, bus.busy, bus.frame_err} !== 3'b000) begin bad++; $display("FAIL reset flags got=%b exp=000", {bus.btn_edge, bus.busy, bus.frame_err}); end
      total++; if (bus.words_issued !== 8'd0) begin bad++; $display("FAIL reset words got=%0d exp=0", bus.words_issued); end
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      int busy_len;
      tick();
      send_word(16'h5A3C, 0);
      total++; if (bus.btn_edge !== 1'b1) begin bad++; $display("FAIL basic btn_edge got=%b exp=1", bus.btn_edge); end
      total++; if (bus.opcode !== 4'h5) begin bad++; $display("FAIL basic opcode got=%h exp=5", bus.opcode); end
      total++; if (bus.instr !== 12'hA3C) begin bad++; $display("FAIL basic instr got=%h exp=a3c", bus.instr); end
      total++; if (bus.words_issued !== 8'd1) begin bad++; $display("FAIL basic words got=%0d exp=1", bus.words_issued); end
      busy_len = (bus.busy === 1'b1) ? 1 : 0;
      bus.ser_frame = 1'b0;
      tick();
      total++; if (bus.btn_edge !== 1'b0) begin bad++; $display("FAIL basic btn_width got=%b exp=0", bus.btn_edge); end
      if (bus.busy === 1'b1) busy_len++;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.busy === 1'b1) busy_len++;
      end
      total++; if (busy_len !== 13) begin bad++; $display("FAIL basic busy_len got=%0d exp=13", busy_len); end
   endtask

   task automatic test_gapped();
      send_word(16'h1FFF, 2);
      total++; if (bus.btn_edge !== 1'b1) begin bad++; $display("FAIL gapped btn_edge got=%b exp=1", bus.btn_edge); end
      total++; if ({bus.opcode, bus.instr} !== 16'h1FFF) begin bad++; $display("FAIL gapped word got=%h exp=1fff", {bus.opcode, bus.instr}); end
      total++; if (bus.words_issued !== 8'd2) begin bad++; $display("FAIL gapped words got=%0d exp=2", bus.words_issued); end
      bus.ser_frame = 1'b0;
      wait_idle("gapped");
   endtask

   task automatic test_short_frame();
      int b0;
      tick();
      b0 = n_btn;
      send_raw(16'h7123, 1'b0, 9, 0);
      bus.ser_frame = 1'b0;
      tick();
      total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL short frame_err got=%b exp=1", bus.frame_err); end
      total++; if ({bus.opcode, bus.instr} !== 16'h1FFF) begin bad++; $display("FAIL short word_kept got=%h exp=1fff", {bus.opcode, bus.instr}); end
      total++; if (bus.words_issued !== 8'd2) begin bad++; $display("FAIL short words got=%0d exp=2", bus.words_issued); end
      tick();
      total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL short err_width got=%b exp=0", bus.frame_err); end
      total++; if (n_btn !== b0) begin bad++; $display("FAIL short no_issue got=%0d exp=%0d", n_btn, b0); end
      send_word(16'h7123, 0);
      total++; if ({bus.btn_edge, bus.opcode, bus.instr} !== 17'h17123) begin bad++; $display("FAIL short recover got=%h exp=17123", {bus.btn_edge, bus.opcode, bus.instr}); end
      total++; if (bus.words_issued !== 8'd3) begin bad++; $display("FAIL short recover_words got=%0d exp=3", bus.words_issued); end
      bus.ser_frame = 1'b0;
      wait_idle("short");
   endtask

   task automatic test_overrun();
      int busy_len, e0, b0;
      tick();
      send_word(16'h2468, 0);
      e0 = n_err;
      busy_len = (bus.busy === 1'b1) ? 1 : 0;
      for (int c = 0; c < 20; c++) begin
         bus.ser_valid = (c == 2 || c == 4);
         bus.ser_bit   = 1'b1;
         tick();
         if (bus.busy === 1'b1) busy_len++;
      end
      bus.ser_valid = 1'b0;
      total++; if (n_err - e0 !== 2) begin bad++; $display("FAIL overrun err_pulses got=%0d exp=2", n_err - e0); end
      total++; if (busy_len !== 13) begin bad++; $display("FAIL overrun busy_len got=%0d exp=13", busy_len); end
      total++; if ({bus.opcode, bus.instr} !== 16'h2468) begin bad++; $display("FAIL overrun word got=%h exp=2468", {bus.opcode, bus.instr}); end
      b0 = n_btn; e0 = n_err;
      send_raw(16'h3333, 1'b0, c_FULL, 0);
      tick(); tick();
      total++; if (n_btn !== b0 || n_err !== e0) begin bad++; $display("FAIL unarmed pulses got=%0d/%0d exp=%0d/%0d", n_btn, n_err, b0, e0); end
      total++; if (bus.words_issued !== 8'd4) begin bad++; $display("FAIL unarmed words got=%0d exp=4", bus.words_issued); end
      bus.ser_frame = 1'b0;
      tick();
      send_word(16'h3333, 0);
      total++; if ({bus.btn_edge, bus.opcode, bus.instr} !== 17'h13333) begin bad++; $display("FAIL rearm issue got=%h exp=13333", {bus.btn_edge, bus.opcode, bus.instr}); end
      total++; if (bus.words_issued !== 8'd5) begin bad++; $display("FAIL rearm words got=%0d exp=5", bus.words_issued); end
      bus.ser_frame = 1'b0;
      wait_idle("overrun");
   endtask

   task automatic test_mid_reset();
      int b0, e0;
      tick();
      send_raw(16'h4BCD, 1'b0, 10, 0);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      total++; if ({bus.opcode, bus.instr} !== 16'h0000) begin bad++; $display("FAIL midrst word got=%h exp=0000", {bus.opcode, bus.instr}); end
      total++; if ({bus.btn_edge, bus.busy, bus.frame_err} !== 3'b000) begin bad++; $display("FAIL midrst flags got=%b exp=000", {bus.btn_edge, bus.busy, bus.frame_err}); end
      total++; if (bus.words_issued !== 8'd0) begin bad++; $display("FAIL midrst words got=%0d exp=0", bus.words_issued); end
      b0 = n_btn; e0 = n_err;
      send_raw(16'h4BCD, 1'b0, c_FULL, 0);
      tick(); tick();
      total++; if (n_btn !== b0 || n_err !== e0 || bus.words_issued !== 8'd0) begin bad++; $display("FAIL midrst unarmed got=%0d/%0d/%0d exp=%0d/%0d/0", n_btn, n_err, bus.words_issued, b0, e0); end
      bus.ser_frame = 1'b0;
      tick();
      send_word(16'h4BCD, 0);
      total++; if ({bus.btn_edge, bus.opcode, bus.instr} !== 17'h14BCD) begin bad++; $display("FAIL midrst issue got=%h exp=14bcd", {bus.btn_edge, bus.opcode, bus.instr}); end
      total++; if (bus.words_issued !== 8'd1) begin bad++; $display("FAIL midrst issue_words got=%0d exp=1", bus.words_issued); end
      bus.ser_frame = 1'b0;
      wait_idle("midrst");
   endtask

   task automatic test_wrap();
      int b0;
      b0 = n_btn;
      for (int i = 0; i < 254; i++) begin
         tick();
         send_word(16'(i * 16'h0101), 0);
         bus.ser_frame = 1'b0;
         wait_idle("wrap");
      end
      total++; if (bus.words_issued !== 8'd255) begin bad++; $display("FAIL wrap pre got=%0d exp=255", bus.words_issued); end
      tick();
      send_word(16'hF00D, 0);
      total++; if (bus.words_issued !== 8'd0) begin bad++; $display("FAIL wrap zero got=%0d exp=0", bus.words_issued); end
      total++; if ({bus.opcode, bus.instr} !== 16'hF00D) begin bad++; $display("FAIL wrap word got=%h exp=f00d", {bus.opcode, bus.instr}); end
      bus.ser_frame = 1'b0;
      wait_idle("wrap_end");
      total++; if (n_btn - b0 !== 255) begin bad++; $display("FAIL wrap issues got=%0d exp=255", n_btn - b0); end
   endtask

`ifdef INSTR_PARITY_EN
   task automatic test_parity();
      int b0;
      tick();
      send_raw(16'h5A3C, 1'b0, 17, 0);
      total++; if ({bus.btn_edge, bus.opcode, bus.instr} !== 17'h15A3C) begin bad++; $display("FAIL parity good got=%h exp=15a3c", {bus.btn_edge, bus.opcode, bus.instr}); end
      bus.ser_frame = 1'b0;
      wait_idle("parity");
      tick();
      b0 = n_btn;
      send_raw(16'h0F0F, 1'b1, 17, 0);
      total++; if (bus.frame_err !== 1'b1 || bus.btn_edge !== 1'b0) begin bad++; $display("FAIL parity bad err/btn got=%b%b exp=10", bus.frame_err, bus.btn_edge); end
      total++; if ({bus.opcode, bus.instr} !== 16'h5A3C || bus.words_issued !== 8'd1) begin bad++; $display("FAIL parity bad kept got=%h/%0d exp=5a3c/1", {bus.opcode, bus.instr}, bus.words_issued); end
      bus.ser_frame = 1'b0;
      tick(); tick();
      total++; if (n_btn !== b0) begin bad++; $display("FAIL parity bad no_issue got=%0d exp=%0d", n_btn, b0); end
   endtask
`endif

   initial begin
      total = 0; bad = 0; n_btn = 0; n_err = 0; n_both = 0;
      rstn = 1'b0; bus.ser_frame = 1'b0; bus.ser_valid = 1'b0; bus.ser_bit = 1'b0;
      test_reset();
      test_basic();
      test_gapped();
      test_short_frame();
      test_overrun();
      test_mid_reset();
      test_wrap();
`ifdef INSTR_PARITY_EN
      test_parity();
`endif
      total++; if (n_both !== 0) begin bad++; $display("FAIL exclusive btn_and_err got=%0d exp=0", n_both); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
